dimm_burst_lane: RTL

- Parametrised data-path lane between the DRAM command block (wr_en/rd_en strobes) and NUM_CHIPS x DQ_PER_CHIP DDR4 devices on one rank.
- Generalises the fixed 4-chip x8 DQ/DM fan-out into a configurable chip count, burst length and latency.
- Adds a write-beat FIFO with per-chip data masking, CWL/CL latency counters, and a read-capture buffer drained through a valid/ready handshake.
- Models DQ at one beat per CLK (SDR abstraction); the DDR serialiser is outside this block.

---
 rtl/dimm_burst_lane_pkg.sv | 27 ++
 rtl/burst_fifo.sv | 52 +++++
 rtl/dimm_burst_lane.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dimm_burst_lane_pkg.sv
// Shared definitions for the DIMM burst lane: FSM states, default rank geometry
// and the beat layout stored in the write FIFO.
package dimm_burst_lane_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_RD_DRAIN
    } lane_state_t;

    localparam int NUM_CHIPS_DEF   = 4;
    localparam int DQ_PER_CHIP_DEF = 8;
    localparam int LANE_W          = NUM_CHIPS_DEF * DQ_PER_CHIP_DEF;

    typedef struct packed {
        logic [NUM_CHIPS_DEF-1:0] mask_n;
        logic [LANE_W-1:0]        data;
    } beat_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_fifo.sv
// Single-clock FIFO for write beats. DEPTH must be a power of two so the
// pointers wrap naturally; a push into a full FIFO is accepted only alongside a pop.
module burst_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dimm_burst_lane.sv
// Data-path lane between the DRAM command block and one rank of DDR4 devices:
// write-beat FIFO with per-chip DM, CWL/CL latency timing and a read-capture buffer.
module dimm_burst_lane
    import dimm_burst_lane_pkg::*;
#(
    parameter int NUM_CHIPS   = NUM_CHIPS_DEF,
    parameter int DQ_PER_CHIP = DQ_PER_CHIP_DEF,
    parameter int BURST_LEN   = 8,
    parameter int CWL         = 12,
    parameter int CL          = 16
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             wr_en,
    input  logic                             rd_en,
    input  logic [NUM_CHIPS*DQ_PER_CHIP-1:0] wdata,
    input  logic [NUM_CHIPS-1:0]             wmask_n,
    input  logic                             wvalid,
    output logic                             wready,
    output logic [NUM_CHIPS*DQ_PER_CHIP-1:0] dq_out,
    output logic [NUM_CHIPS-1:0]             dm_n_out,
    output logic                             dq_oe,
    input  logic [NUM_CHIPS*DQ_PER_CHIP-1:0] dq_in,
    output logic [NUM_CHIPS*DQ_PER_CHIP-1:0] rdata,
    output logic                             rvalid,
    input  logic                             rready,
    output logic                             busy,
    output logic                             wr_underrun,
    output logic                             cmd_err
);
    localparam int LW = NUM_CHIPS * DQ_PER_CHIP;
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(max_int(CWL, CL) + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    // The wait states cover the cycles between the command and the cycle whose
    // closing edge launches (write) or samples (read) the first beat.
    localparam logic [CW-1:0] WR_LOAD = (CWL >= 2) ? CW'(CWL - 2) : '0;
    localparam logic [CW-1:0] RD_LOAD = (CL >= 2) ? CW'(CL - 2) : '0;

    typedef struct packed {
        logic [NUM_CHIPS-1:0] mask_n;
        logic [LW-1:0]        data;
    } lane_beat_t;

    lane_state_t    state;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  beat;
    logic [BW-1:0]  rptr;
    logic [LW-1:0]  rbuf [BURST_LEN];

    lane_beat_t     fifo_wr;
    lane_beat_t     fifo_rd;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           wr_issue;

    assign fifo_wr.mask_n = wmask_n;
    assign fifo_wr.data   = wdata;
    assign fifo_push      = wvalid && !fifo_full;
    assign wready         = !fifo_full;
    assign busy           = (state != ST_IDLE);
    assign rdata          = rvalid ? rbuf[rptr] : '0;

    // A beat is launched on every edge whose following cycle is a burst beat.
    assign wr_issue = ((state == ST_WR_WAIT) && (cnt == '0)) ||
                      ((state == ST_WR_BURST) && (beat != LAST_BEAT)) ||
                      ((state == ST_IDLE) && wr_en && (CWL == 1));
    assign fifo_pop = wr_issue && !fifo_empty;

    burst_fifo #(
        .WIDTH ($bits(lane_beat_t)),
        .DEPTH (BURST_LEN)
    ) u_wr_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (fifo_push),
        .push_data (fifo_wr),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            beat        <= '0;
            rptr        <= '0;
            dq_out      <= '0;
            dm_n_out    <= '1;
            dq_oe       <= 1'b0;
            rvalid      <= 1'b0;
            wr_underrun <= 1'b0;
            cmd_err     <= 1'b0;
            for (int i = 0; i < BURST_LEN; i++) rbuf[i] <= '0;
        end else begin
            wr_underrun <= 1'b0;
            cmd_err     <= 1'b0;
            if (state != ST_IDLE) cmd_err <= wr_en | rd_en;

            if (wr_issue) begin
                dq_oe <= 1'b1;
                if (!fifo_empty) begin
                    dq_out   <= fifo_rd.data;
                    dm_n_out <= fifo_rd.mask_n;
                end else begin
                    dq_out      <= '0;
                    dm_n_out    <= '0;
                    wr_underrun <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (wr_en) begin
                        cmd_err <= rd_en;
                        if (CWL == 1) begin
                            state <= ST_WR_BURST;
                        end else begin
                            state <= ST_WR_WAIT;
                            cnt   <= WR_LOAD;
                        end
                    end else if (rd_en) begin
                        if (CL == 1) begin
                            state <= ST_RD_BURST;
                        end else begin
                            state <= ST_RD_WAIT;
                            cnt   <= RD_LOAD;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_WR_BURST;
                        beat  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR_BURST: begin
                    if (beat == LAST_BEAT) begin
                        state    <= ST_IDLE;
                        dq_oe    <= 1'b0;
                        dq_out   <= '0;
                        dm_n_out <= '1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RD_BURST;
                        beat  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RD_BURST: begin
                    rbuf[beat] <= dq_in;
                    if (beat == LAST_BEAT) begin
                        state  <= ST_RD_DRAIN;
                        rptr   <= '0;
                        rvalid <= 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                ST_RD_DRAIN: begin
                    if (rready) begin
                        if (rptr == LAST_BEAT) begin
                            state  <= ST_IDLE;
                            rvalid <= 1'b0;
                        end else begin
                            rptr <= rptr + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
